// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared mul/div op encodings, default width and unit state type
package mips_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - one combinational shift-add (mul) or restoring shift-subtract (div) step
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc_next
);
    logic [XLEN:0] sum;
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        // Partial remainder shifted left with the next dividend bit; the extra bit keeps 2*rem+1 exact.
        rem_sh = acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opnd};
        if (is_div) begin
            if (diff[XLEN])
                acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            else
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - execute-stage iterative MULT/DIV unit with HI/LO registers and stall request
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hilo_rd,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opnd;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              dz;

    logic              is_md_op;
    logic              signed_op;
    logic              is_div_op;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_hi;
    logic [XLEN-1:0]   res_lo;

    always_comb begin
        is_md_op  = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        is_div_op = (op == MD_DIV) || (op == MD_DIVU);
        // Magnitude of the most-negative value wraps to 2^(XLEN-1), which is correct as unsigned.
        abs_a     = (signed_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
        abs_b     = (signed_op && rt_val[XLEN-1]) ? -rt_val : rt_val;
    end

    md_iter_core #(.XLEN(XLEN)) u_iter (
        .is_div   (is_div),
        .acc      (acc),
        .opnd     (opnd),
        .acc_next (acc_next)
    );

    always_comb begin
        prod = neg_q ? -acc_next : acc_next;
        if (dz) begin
            // Divide-by-zero result was preloaded at accept; no iteration applies.
            res_hi = acc[2*XLEN-1:XLEN];
            res_lo = acc[XLEN-1:0];
        end else if (!is_div) begin
            res_hi = prod[2*XLEN-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end else begin
            res_lo = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
            res_hi = neg_r ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        end
    end

    assign stall_req = busy & (hilo_rd | start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !flush) begin
                        if (is_md_op) begin
                            is_div <= is_div_op;
                            neg_q  <= signed_op & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
                            neg_r  <= signed_op & rs_val[XLEN-1];
                            state  <= ST_RUN;
                            busy   <= 1'b1;
                            if (is_div_op && (rt_val == '0)) begin
                                dz   <= 1'b1;
                                cnt  <= '0;
                                acc  <= {rs_val, {XLEN{1'b1}}};
                                opnd <= '0;
                            end else begin
                                dz   <= 1'b0;
                                cnt  <= CNT_W'(XLEN - 1);
                                acc  <= {{XLEN{1'b0}}, (is_div_op ? abs_a : abs_b)};
                                opnd <= is_div_op ? abs_b : abs_a;
                            end
                        end else if (op == MD_MTHI) begin
                            hi <= rs_val;
                        end else if (op == MD_MTLO) begin
                            lo <= rs_val;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        hi       <= res_hi;
                        lo       <= res_lo;
                        done     <= 1'b1;
                        div_zero <= dz;
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
